// File: rtl/frame_scheduler.sv
// Frame-locked scheduler for the ws2811 driver array: frame timer, double-buffer
// bank control, universe completion tracking and a synchronised start to all drivers.
module frame_scheduler #(
  parameter int UNIVERSES   = 16,
  parameter int CLOCK       = 50000000,
  parameter int FRAME_RATE  = 20,
  parameter int STALE_LIMIT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_done,
  input  logic [7:0]           rx_universe,
  input  logic [UNIVERSES-1:0] sending,
  output logic [UNIVERSES-1:0] start,
  output logic                 rx_bank,
  output logic                 tx_bank,
  output logic                 frame_tick,
  output logic [UNIVERSES-1:0] pending,
  output logic                 forced,
  output logic                 err_range,
  output logic                 err_dup
);

  localparam int PERIOD  = CLOCK / FRAME_RATE;
  localparam int CNT_W   = $clog2(PERIOD);
  localparam int STALE_W = $clog2(STALE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic [STALE_W-1:0]   stale_cnt, stale_nxt, stale_inc;
  logic                 force_q, force_nxt;
  logic                 rx_in_range;
  logic                 rx_valid;
  logic [UNIVERSES-1:0] rx_onehot;

  // Frame timer runs free regardless of scheduler state.
  always_ff @(posedge clk) begin
    if (!rst_n)          tick_cnt <= '0;
    else if (frame_tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign frame_tick  = (tick_cnt == CNT_W'(PERIOD - 1));
  assign tx_bank     = ~rx_bank;
  assign rx_in_range = (int'(rx_universe) < UNIVERSES);
  assign rx_valid    = rx_done && rx_in_range;
  assign rx_onehot   = rx_valid ? (UNIVERSES'(1) << rx_universe) : '0;
  assign stale_inc   = stale_cnt + STALE_W'(1);

  always_comb begin
    state_nxt = state;
    stale_nxt = stale_cnt;
    force_nxt = force_q;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          if (&pending) begin
            state_nxt = DRAIN;
            stale_nxt = '0;
          end else if (|pending) begin
            stale_nxt = stale_inc;
            if (stale_inc >= STALE_W'(STALE_LIMIT)) begin
              state_nxt = DRAIN;
              force_nxt = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (sending == '0) state_nxt = SWAP;
      end
      SWAP: begin
        state_nxt = IDLE;
        stale_nxt = '0;
        force_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      stale_cnt <= '0;
      force_q   <= 1'b0;
      rx_bank   <= 1'b0;
      pending   <= '0;
      start     <= '0;
      forced    <= 1'b0;
      err_range <= 1'b0;
      err_dup   <= 1'b0;
    end else begin
      state     <= state_nxt;
      stale_cnt <= stale_nxt;
      force_q   <= force_nxt;
      err_range <= rx_done && !rx_in_range;
      err_dup   <= |(pending & rx_onehot);
      // An rx_done landing in SWAP wrote the bank now going on display, so it is dropped.
      if (state == SWAP) begin
        rx_bank <= ~rx_bank;
        pending <= '0;
        start   <= '1;
        forced  <= force_q;
      end else begin
        pending <= pending | rx_onehot;
        start   <= '0;
        forced  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences the per-universe ws2811 driver array from the SPI lights receiver.
- Owns the frame-rate timer and a double-buffered pixel store: the receiver writes bank rx_bank while the drivers read bank tx_bank.
- At each frame tick, once every universe has been received, the block waits for all drivers to go idle, swaps the banks, then pulses start to all universes together. This gives tear-free, frame-locked output.

Parameters:
- UNIVERSES, 16, number of driver channels and width of the per-universe vectors.
- CLOCK, 50000000, clk frequency in Hz.
- FRAME_RATE, 20, frames per second. PERIOD = CLOCK/FRAME_RATE cycles, integer division, must be >= 4.
- STALE_LIMIT, 5, ticks a partial frame may wait before a forced swap. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_done  in  1  one-cycle pulse: universe rx_universe fully written into rx_bank
- rx_universe  in  8  universe index qualified by rx_done
- sending  in  UNIVERSES  per-driver busy flags
- start  out  UNIVERSES  one-cycle start pulse to each driver
- rx_bank  out  1  bank the receiver writes
- tx_bank  out  1  bank the drivers read; always equals ~rx_bank
- frame_tick  out  1  one-cycle pulse each PERIOD cycles
- pending  out  UNIVERSES  universes received since the last swap
- forced  out  1  one-cycle pulse when a swap was forced on a partial frame
- err_range  out  1  one-cycle pulse: rx_done with rx_universe >= UNIVERSES
- err_dup  out  1  one-cycle pulse: rx_done for a universe already pending

Behaviour:
Reset (rst_n low at a clk edge), overriding all other activity including mid-swap:
- tick counter = 0, state = IDLE, stale counter = 0.
- rx_bank = 0, tx_bank = 1.
- start, pending, frame_tick, forced, err_range and err_dup all = 0.

Timer:
- Counter runs 0..PERIOD-1 and wraps to 0.
- frame_tick is high in the cycle the counter equals PERIOD-1.
- The counter runs free in every state.

Pending capture:
- On rx_done with a valid index, set pending[rx_universe].
- If that bit was already set, also pulse err_dup on the next cycle; pending is unchanged.
- If the index is out of range, pulse err_range on the next cycle; pending is unchanged.

FSM (registered state):
- IDLE:
  - On frame_tick with pending all ones: go to DRAIN, clear the stale counter.
  - On frame_tick with pending nonzero but incomplete: increment the stale counter. If it reaches STALE_LIMIT, go to DRAIN and set an internal force flag.
  - On frame_tick with pending zero: stay in IDLE; the stale counter is unchanged.
- DRAIN:
  - Stay while any sending bit is high.
  - When sending == 0, go to SWAP.
  - frame_tick is ignored here; the timer keeps running.
  - rx_done still ORs into pending (data is in the pre-swap bank).
- SWAP, one cycle:
  - Toggle rx_bank and tx_bank.
  - Clear pending, including any rx_done in this same cycle; that universe's data is in the bank being displayed.
  - Register start = all ones.
  - Register forced = the force flag; clear the force flag and the stale counter.
  - Go to IDLE.

Timing and output rules:
- start is high for exactly one cycle, the cycle after SWAP; the new tx_bank is visible in that same cycle.
- Latency with drivers idle: tick at cycle T, DRAIN at T+1, SWAP at T+2, start and new banks at T+3.
- A tick arriving in the start cycle (T+3) is evaluated normally in IDLE.
- Error checks also apply to an rx_done that arrives in the SWAP cycle.
- err_range and err_dup never alter state, banks or pending.

Test Plan (CLOCK=1000, FRAME_RATE=10 so PERIOD=100; UNIVERSES=4; STALE_LIMIT=2):
- Reset, then idle 300 cycles -> frame_tick at cycles 99, 199 and 299; start never asserted; rx_bank=0, tx_bank=1.
- rx_done for universes 0..3 before cycle 99, sending=0 -> DRAIN at 100, SWAP at 101, start=4'b1111 only at cycle 102, rx_bank=1, tx_bank=0, pending=0.
- Complete frame with sending[2]=1 until cycle 140 -> no start before 141; swap follows 1 cycle after sending clears; start high exactly 1 cycle.
- Only universes 0 and 1 received -> no swap at tick 1; forced swap at tick 2 (cycle 199) -> start at 202, forced pulse at 202, pending=0.
- rx_done universe 5 -> err_range pulse, pending unchanged. rx_done universe 1 twice -> err_dup pulse, pending=4'b0010.
- rst_n low during DRAIN -> next cycle state IDLE, pending=0, rx_bank=0, and no start ever issued for the aborted frame.
